seq_divider_32: RTL and testbench

//  Iterative restoring divider, the inverse arithmetic unit to the 32-bit carry-select adder.

---
 rtl/seq_divider_32_pkg.sv | 17 +
 rtl/seq_divider_32_csa.sv | 39 +++
 rtl/seq_divider_32.sv | 182 ++++++++++++++++++
 tb/tb_seq_divider_32.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_32_pkg.sv
// Shared divider constants: state encodings, datapath width and the
// block size of the carry-select adder used for subtraction/negation.
package seq_divider_32_pkg;

   // Width of the arithmetic datapath, shared with the future multiplier.
   localparam int DIV_WIDTH = 32;

   // Bits per carry-select block inside csa_32_bit.
   localparam int CSA_BLOCK = 4;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'd0,
      DIV_CALC   = 2'd1,
      DIV_FINISH = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_divider_32_csa.sv
// 32-bit carry-select adder. Each block precomputes its sum for both
// incoming carries and the real carry only selects between them.
module csa_32_bit
   import seq_divider_32_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] a,
   input  logic [DIV_WIDTH-1:0] b,
   input  logic                 cin,
   output logic [DIV_WIDTH-1:0] sum,
   output logic                 cout
);

   localparam int NBLK = DIV_WIDTH / CSA_BLOCK;

   logic [NBLK:0] carry;

   assign carry[0] = cin;
   assign cout     = carry[NBLK];

   genvar gi;
   generate
      for (gi = 0; gi < NBLK; gi++) begin : g_blk
         logic [CSA_BLOCK:0] sum0;
         logic [CSA_BLOCK:0] sum1;

         // Candidate sums for carry-in 0 and carry-in 1.
         assign sum0 = {1'b0, a[gi*CSA_BLOCK +: CSA_BLOCK]}
                     + {1'b0, b[gi*CSA_BLOCK +: CSA_BLOCK]};
         assign sum1 = {1'b0, a[gi*CSA_BLOCK +: CSA_BLOCK]}
                     + {1'b0, b[gi*CSA_BLOCK +: CSA_BLOCK]}
                     + (CSA_BLOCK+1)'(1);

         assign sum[gi*CSA_BLOCK +: CSA_BLOCK] = carry[gi] ? sum1[CSA_BLOCK-1:0]
                                                           : sum0[CSA_BLOCK-1:0];
         assign carry[gi+1] = carry[gi] ? sum1[CSA_BLOCK] : sum0[CSA_BLOCK];
      end
   endgenerate

endmodule

// File: rtl/seq_divider_32.sv
// Iterative restoring divider, one trial subtraction per clock.
// Fixed latency: result_valid pulses in the cycle after the 33rd edge
// following the accepting edge, independent of operand values.
module seq_divider_32
   import seq_divider_32_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
)(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             result_valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int            CW         = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   div_state_t       state_reg;
   div_state_t       state_next;

   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] a_reg;            // partial remainder accumulator
   logic [WIDTH-1:0] q_reg;            // dividend magnitude, becomes quotient
   logic [WIDTH-1:0] d_reg;            // divisor magnitude
   logic             q_neg_reg;
   logic             r_neg_reg;
   logic             dz_reg;

   logic             result_valid_reg;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             div_by_zero_reg;

   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] sub_a;
   logic [WIDTH-1:0] sub_b;
   logic [WIDTH-1:0] sub_sum;
   logic             sub_cout;
   logic [WIDTH-1:0] neg_b;
   logic [WIDTH-1:0] neg_sum;
   logic             neg_cout;
   logic             take;
   logic             dvd_neg;
   logic             dvs_neg;

   assign a_shift = {a_reg[WIDTH-2:0], q_reg[WIDTH-1]};
   assign dvd_neg = op_signed & dividend[WIDTH-1];
   assign dvs_neg = op_signed & divisor[WIDTH-1];

   // The trial subtractor is idle outside CALC, so it doubles as a negator:
   // -dividend while waiting for start, -A during FINISH.
   // The second adder negates the divisor in IDLE and Q during FINISH.
   always_comb begin
      sub_a = '0;
      sub_b = ~dividend;
      neg_b = ~divisor;
      case (state_reg)
         DIV_CALC: begin
            sub_a = a_shift;
            sub_b = ~d_reg;
            neg_b = ~q_reg;
         end
         DIV_FINISH: begin
            sub_a = '0;
            sub_b = ~a_reg;
            neg_b = ~q_reg;
         end
         default: ;
      endcase
   end

   csa_32_bit u_trial (
      .a    (sub_a),
      .b    (sub_b),
      .cin  (1'b1),
      .sum  (sub_sum),
      .cout (sub_cout)
   );

   csa_32_bit u_negate (
      .a    ('0),
      .b    (neg_b),
      .cin  (1'b1),
      .sum  (neg_sum),
      .cout (neg_cout)
   );

   // Subtraction succeeds when there is no borrow, or when the bit shifted
   // out of A makes the true shifted value exceed any WIDTH-bit divisor.
   assign take = sub_cout | a_reg[WIDTH-1];

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= DIV_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: IDLE -> CALC -> FINISH -> IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         DIV_IDLE:   if (start) state_next = DIV_CALC;
         DIV_CALC:   if (count_reg == LAST_COUNT) state_next = DIV_FINISH;
         DIV_FINISH: state_next = DIV_IDLE;
         default:    state_next = DIV_IDLE;
      endcase
   end

   // Operand capture, shift/subtract iterations and result registration.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_reg        <= '0;
         a_reg            <= '0;
         q_reg            <= '0;
         d_reg            <= '0;
         q_neg_reg        <= 1'b0;
         r_neg_reg        <= 1'b0;
         dz_reg           <= 1'b0;
         result_valid_reg <= 1'b0;
         quotient_reg     <= '0;
         remainder_reg    <= '0;
         div_by_zero_reg  <= 1'b0;
      end else begin
         result_valid_reg <= 1'b0;
         case (state_reg)
            DIV_IDLE: begin
               if (start) begin
                  q_reg     <= dvd_neg ? sub_sum : dividend;
                  d_reg     <= dvs_neg ? neg_sum : divisor;
                  q_neg_reg <= op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg_reg <= dvd_neg;
                  // ~0 + 1 carries out only for a zero divisor.
                  dz_reg    <= neg_cout;
                  a_reg     <= '0;
                  count_reg <= '0;
               end
            end
            DIV_CALC: begin
               if (take) begin
                  a_reg <= sub_sum;
                  q_reg <= {q_reg[WIDTH-2:0], 1'b1};
               end else begin
                  a_reg <= a_shift;
                  q_reg <= {q_reg[WIDTH-2:0], 1'b0};
               end
               count_reg <= count_reg + CW'(1);
            end
            DIV_FINISH: begin
               result_valid_reg <= 1'b1;
               // With a zero divisor every trial succeeds, so A ends up holding
               // the dividend magnitude and the sign fix-up restores the
               // dividend exactly as sampled.
               remainder_reg    <= r_neg_reg ? sub_sum : a_reg;
               div_by_zero_reg  <= dz_reg;
               if (dz_reg) begin
                  quotient_reg <= '0;
               end else begin
                  quotient_reg <= q_neg_reg ? neg_sum : q_reg;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = (state_reg != DIV_IDLE);
   assign result_valid = result_valid_reg;
   assign quotient     = quotient_reg;
   assign remainder    = remainder_reg;
   assign div_by_zero  = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider_32.sv
// Directed bench for seq_divider_32: arithmetic results, fixed latency,
// divide-by-zero, ignored restarts, back-to-back issue and async reset.
module tb_seq_divider_32;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        op_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        result_valid;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;
   int busy_bad;

   seq_divider_32 dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .op_signed    (op_signed),
      .dividend     (dividend),
      .divisor      (divisor),
      .busy         (busy),
      .result_valid (result_valid),
      .quotient     (quotient),
      .remainder    (remainder),
      .div_by_zero  (div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a request and let the next edge accept it; returns 1ns after that edge.
   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      start     = 1'b1;
      op_signed = sgn;
      dividend  = a;
      divisor   = b;
      @(posedge clock); #1;
      start     = 1'b0;
   endtask

   // Count edges until result_valid is seen (bounded); busy must stay high meanwhile.
   task automatic wait_result(output int n);
      n = 0;
      busy_bad = 0;
      while (result_valid !== 1'b1 && n < 100) begin
         if (busy !== 1'b1) busy_bad++;
         @(posedge clock); #1;
         n++;
      end
   endtask

   task automatic run_div(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz);
      int n;
      issue(sgn, a, b);
      wait_result(n);
      chk({tag, ".latency"}, n, 33);
      chk({tag, ".busy_during"}, busy_bad, 0);
      chk({tag, ".busy_at_result"}, {31'd0, busy}, 32'd0);
      chk({tag, ".q"}, quotient, eq);
      chk({tag, ".r"}, remainder, er);
      chk({tag, ".dz"}, {31'd0, div_by_zero}, {31'd0, edz});
      $display("div %s signed=%0d %h/%h -> q=%h r=%h dz=%0d after %0d cycles",
               tag, sgn, a, b, quotient, remainder, div_by_zero, n);
   endtask

   initial begin
      int n;
      int m;
      int rv_seen;

      reset_n   = 1'b1;
      start     = 1'b0;
      op_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;

      // Reset state
      #2 reset_n = 1'b0;
      @(posedge clock); @(posedge clock); #1;
      chk("reset.busy", {31'd0, busy}, 32'd0);
      chk("reset.valid", {31'd0, result_valid}, 32'd0);
      chk("reset.q", quotient, 32'd0);
      chk("reset.r", remainder, 32'd0);
      chk("reset.dz", {31'd0, div_by_zero}, 32'd0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Basic unsigned and signed division
      run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      @(posedge clock); #1;
      chk("u100_7.pulse_drop", {31'd0, result_valid}, 32'd0);
      run_div("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      run_div("s100_-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
      run_div("s-7_-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);

      // Boundary operands
      run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      run_div("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0);
      run_div("u_max_maxm1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0);

      // Divide by zero, then a normal op clears the flag
      run_div("u5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd5, 1'b1);
      run_div("s-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'hFFFF_FFFB, 1'b1);
      run_div("s9_3", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

      // Start pulsed at E10 while busy must be ignored
      issue(1'b0, 32'd1000, 32'd10);
      repeat (9) begin @(posedge clock); #1; end
      start = 1'b1; dividend = 32'd7; divisor = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      wait_result(m);
      chk("ignore.latency", 10 + m, 33);
      chk("ignore.q", quotient, 32'd100);
      chk("ignore.r", remainder, 32'd0);
      $display("div ignore unsigned 1000/10 with restart at E10 -> q=%h r=%h after %0d cycles",
               quotient, remainder, 10 + m);

      // Back-to-back: start in the result_valid cycle
      issue(1'b0, 32'd77, 32'd7);
      chk("b2b.busy", {31'd0, busy}, 32'd1);
      chk("b2b.q_held", quotient, 32'd100);
      wait_result(m);
      chk("b2b.spacing", 1 + m, 34);
      chk("b2b.q", quotient, 32'd11);
      chk("b2b.r", remainder, 32'd0);
      $display("div b2b unsigned 77/7 -> q=%h r=%h spacing %0d cycles", quotient, remainder, 1 + m);

      // Asynchronous reset at E15 abandons the operation
      @(posedge clock); #1;
      issue(1'b0, 32'd500, 32'd3);
      repeat (14) begin @(posedge clock); #1; end
      reset_n = 1'b0;
      #1;
      chk("arst.busy", {31'd0, busy}, 32'd0);
      chk("arst.valid", {31'd0, result_valid}, 32'd0);
      chk("arst.q", quotient, 32'd0);
      chk("arst.r", remainder, 32'd0);
      chk("arst.dz", {31'd0, div_by_zero}, 32'd0);
      @(posedge clock); @(posedge clock); #1;
      reset_n = 1'b1;
      rv_seen = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (result_valid !== 1'b0 || busy !== 1'b0) rv_seen++;
      end
      chk("arst.no_pulse", rv_seen, 0);
      $display("reset at E15 -> busy=%0d q=%h, idle after release", busy, quotient);
      run_div("u500_3", 1'b0, 32'd500, 32'd3, 32'd166, 32'd2, 1'b0);

      n = errors;
      $display("Result: errors=%0d of %0d checks", n, checks);
      $finish;
   end

endmodule
